hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 163 ++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for a 5-stage pipeline: tracks DX/XM/MW destination tags,
// selects operand forwarding, raises decode stalls and sequences a multi-cycle mult/div unit.
module hazard_scoreboard #(
  parameter int REG_AW    = 5,
  parameter int MD_CYCLES = 32,
  parameter int BYPASS_EN = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fd_valid,
  input  logic [REG_AW-1:0] fd_src_a,
  input  logic [REG_AW-1:0] fd_src_b,
  input  logic              fd_src_a_en,
  input  logic              fd_src_b_en,
  input  logic [REG_AW-1:0] fd_dst,
  input  logic              fd_dst_we,
  input  logic [1:0]        fd_class,
  input  logic              flush,
  output logic              stall,
  output logic [1:0]        bypass_a_sel,
  output logic [1:0]        bypass_b_sel,
  output logic              md_busy,
  output logic              md_wb_valid,
  output logic [REG_AW-1:0] md_wb_dst
);

  // state   | meaning
  // MD_IDLE | unit free
  // MD_BUSY | operation in flight, md_count counts down to 0
  // MD_DONE | one-cycle result writeback of md_dst

  localparam logic [1:0] CLS_ALU  = 2'b00;
  localparam logic [1:0] CLS_LOAD = 2'b01;
  localparam logic [1:0] CLS_MD   = 2'b10;
  localparam logic [7:0] MD_LAST  = 8'(MD_CYCLES - 1);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] src_a;
    logic              src_a_en;
    logic [REG_AW-1:0] src_b;
    logic              src_b_en;
    logic [REG_AW-1:0] dst;
    logic              we;
    logic [1:0]        cls;
  } tag_t;

  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

  tag_t              dx, xm, mw, fd_tag, dx_nxt;
  md_state_t         md_state, md_state_nxt;
  logic [7:0]        md_count, md_count_nxt;
  logic [REG_AW-1:0] md_dst, md_dst_nxt, md_dst_cur;
  logic              md_pending, md_start, dx_is_md;
  logic              hz_load, hz_md, hz_struct, hz_wb, hz_nobyp, stall_raw;
  logic              unused_tag_bits;

  function automatic logic is_writer(tag_t t);
    return t.valid && t.we && (t.dst != '0) && !t.cls[1];
  endfunction

  function automatic logic src_hit(logic [REG_AW-1:0] a, logic a_en,
                                   logic [REG_AW-1:0] b, logic b_en,
                                   logic [REG_AW-1:0] r);
    return (a_en && (a != '0) && (a == r)) || (b_en && (b != '0) && (b == r));
  endfunction

  // Loads are still in memory while in XM, so only ALU results forward from there.
  function automatic logic [1:0] fwd_sel(logic en, logic [REG_AW-1:0] idx,
                                         tag_t xm_t, tag_t mw_t);
    if (!en || idx == '0)                                      return 2'd0;
    if (is_writer(xm_t) && xm_t.cls == CLS_ALU && xm_t.dst == idx) return 2'd1;
    if (is_writer(mw_t) && mw_t.dst == idx)                    return 2'd2;
    return 2'd0;
  endfunction

  assign fd_tag = '{valid: fd_valid, src_a: fd_src_a, src_a_en: fd_src_a_en,
                    src_b: fd_src_b, src_b_en: fd_src_b_en, dst: fd_dst,
                    we: fd_dst_we, cls: fd_class};

  always_comb begin
    dx_is_md   = dx.valid && (dx.cls == CLS_MD);
    md_pending = dx_is_md || (md_state != MD_IDLE);
    md_dst_cur = dx_is_md ? dx.dst : md_dst;
    md_start   = dx_is_md && dx.we && (dx.dst != '0);

    hz_load   = is_writer(dx) && (dx.cls == CLS_LOAD) &&
                src_hit(fd_src_a, fd_src_a_en, fd_src_b, fd_src_b_en, dx.dst);
    hz_md     = md_pending && (md_dst_cur != '0) &&
                (src_hit(fd_src_a, fd_src_a_en, fd_src_b, fd_src_b_en, md_dst_cur) ||
                 (fd_dst_we && (fd_dst == md_dst_cur)));
    hz_struct = (fd_class == CLS_MD) && md_pending;
    // The md result owns the writeback port when an op issued now would reach it.
    hz_wb     = is_writer(fd_tag) && (md_state == MD_BUSY) && (md_count == 8'd2);
    hz_nobyp  = (BYPASS_EN == 0) &&
                ((is_writer(dx) && src_hit(fd_src_a, fd_src_a_en, fd_src_b, fd_src_b_en, dx.dst)) ||
                 (is_writer(xm) && src_hit(fd_src_a, fd_src_a_en, fd_src_b, fd_src_b_en, xm.dst)) ||
                 (is_writer(mw) && src_hit(fd_src_a, fd_src_a_en, fd_src_b, fd_src_b_en, mw.dst)));

    stall_raw = fd_valid && !flush && (hz_load || hz_md || hz_struct || hz_wb || hz_nobyp);

    dx_nxt       = fd_tag;
    dx_nxt.valid = fd_valid && !stall_raw && !flush;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dx.valid <= 1'b0;
      xm.valid <= 1'b0;
      mw.valid <= 1'b0;
    end else begin
      dx <= dx_nxt;
      xm <= dx;
      mw <= xm;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      md_state <= MD_IDLE;
      md_count <= 8'd0;
      md_dst   <= '0;
    end else begin
      md_state <= md_state_nxt;
      md_count <= md_count_nxt;
      md_dst   <= md_dst_nxt;
    end
  end

  always_comb begin
    md_state_nxt = md_state;
    md_count_nxt = md_count;
    md_dst_nxt   = md_dst;
    case (md_state)
      MD_IDLE: begin
        if (md_start) begin
          md_state_nxt = MD_BUSY;
          md_count_nxt = MD_LAST;
          md_dst_nxt   = dx.dst;
        end
      end
      MD_BUSY: begin
        if (md_count == 8'd0) md_state_nxt = MD_DONE;
        else                  md_count_nxt = md_count - 8'd1;
      end
      MD_DONE: md_state_nxt = MD_IDLE;
      default: md_state_nxt = MD_IDLE;
    endcase
  end

  assign stall        = !reset && stall_raw;
  assign bypass_a_sel = (reset || BYPASS_EN == 0) ? 2'd0 : fwd_sel(dx.src_a_en, dx.src_a, xm, mw);
  assign bypass_b_sel = (reset || BYPASS_EN == 0) ? 2'd0 : fwd_sel(dx.src_b_en, dx.src_b, xm, mw);
  assign md_busy      = !reset && ((md_state == MD_BUSY) || (md_state == MD_DONE));
  assign md_wb_valid  = !reset && (md_state == MD_DONE);
  assign md_wb_dst    = md_wb_valid ? md_dst : '0;

  // Source fields only matter in DX; later stages carry them along untouched.
  assign unused_tag_bits = ^{dx.src_a, dx.src_a_en, dx.src_b, dx.src_b_en,
                             xm.src_a, xm.src_a_en, xm.src_b, xm.src_b_en,
                             mw.src_a, mw.src_a_en, mw.src_b, mw.src_b_en, mw.cls};

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a forwarding instance and a stall-only
// instance share the decode stimulus; each step checks hand-computed outputs.
module tb_hazard_scoreboard;
  localparam int AW = 5;
  localparam logic [1:0] ALU = 2'b00, LOAD = 2'b01, MD = 2'b10, NW = 2'b11;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          fd_valid, fd_src_a_en, fd_src_b_en, fd_dst_we, flush;
  logic [AW-1:0] fd_src_a, fd_src_b, fd_dst;
  logic [1:0]    fd_class;

  logic          stall_b, busy_b, wbv_b, stall_s, busy_s, wbv_s;
  logic [1:0]    sela_b, selb_b, sela_s, selb_s;
  logic [AW-1:0] wbd_b, wbd_s;

  int n_cmp = 0;
  int n_err = 0;
  int pulses;

  always #5 clock = ~clock;

  hazard_scoreboard #(.REG_AW(AW), .MD_CYCLES(4), .BYPASS_EN(1)) u_byp (
    .clock(clock), .reset(reset), .fd_valid(fd_valid),
    .fd_src_a(fd_src_a), .fd_src_b(fd_src_b),
    .fd_src_a_en(fd_src_a_en), .fd_src_b_en(fd_src_b_en),
    .fd_dst(fd_dst), .fd_dst_we(fd_dst_we), .fd_class(fd_class), .flush(flush),
    .stall(stall_b), .bypass_a_sel(sela_b), .bypass_b_sel(selb_b),
    .md_busy(busy_b), .md_wb_valid(wbv_b), .md_wb_dst(wbd_b));

  hazard_scoreboard #(.REG_AW(AW), .MD_CYCLES(4), .BYPASS_EN(0)) u_stl (
    .clock(clock), .reset(reset), .fd_valid(fd_valid),
    .fd_src_a(fd_src_a), .fd_src_b(fd_src_b),
    .fd_src_a_en(fd_src_a_en), .fd_src_b_en(fd_src_b_en),
    .fd_dst(fd_dst), .fd_dst_we(fd_dst_we), .fd_class(fd_class), .flush(flush),
    .stall(stall_s), .bypass_a_sel(sela_s), .bypass_b_sel(selb_s),
    .md_busy(busy_s), .md_wb_valid(wbv_s), .md_wb_dst(wbd_s));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic fd(input logic v, input logic [AW-1:0] a, input logic aen,
                    input logic [AW-1:0] b, input logic ben,
                    input logic [AW-1:0] d, input logic we, input logic [1:0] cls);
    fd_valid = v;  fd_src_a = a; fd_src_a_en = aen; fd_src_b = b; fd_src_b_en = ben;
    fd_dst = d;    fd_dst_we = we; fd_class = cls;
  endtask

  task automatic fd_idle();
    fd(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, ALU);
  endtask

  initial begin
    fd_idle();
    flush = 1'b0;
    reset = 1'b1;
    tick(); tick();
    settle();
    chk("rst_stall",  8'(stall_b), 8'd0);
    chk("rst_busy",   8'(busy_b),  8'd0);
    chk("rst_wbv",    8'(wbv_b),   8'd0);
    chk("rst_sel_a",  8'(sela_b),  8'd0);
    chk("rst_stall_s", 8'(stall_s), 8'd0);
    reset = 1'b0;
    tick();

    // add r3 ; add r4,r3,r3 back-to-back
    fd(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, ALU); settle();
    chk("add3_stall", 8'(stall_b), 8'd0);
    tick();
    fd(1, 5'd3, 1, 5'd3, 1, 5'd4, 1, ALU); settle();
    chk("add4_stall", 8'(stall_b), 8'd0);
    tick();
    fd(1, 5'd1, 1, 5'd2, 1, 5'd9, 1, ALU); settle();
    chk("b2b_sel_a", 8'(sela_b), 8'd1);
    chk("b2b_sel_b", 8'(selb_b), 8'd1);
    tick();
    // one-gap: add r9 ; bubble ; add r10,r9,r4
    fd_idle(); tick();
    fd(1, 5'd9, 1, 5'd4, 1, 5'd10, 1, ALU); tick();
    fd(1, 5'd1, 1, 5'd2, 1, 5'd0, 1, ALU); settle();
    chk("gap_sel_a", 8'(sela_b), 8'd2);
    chk("gap_sel_b", 8'(selb_b), 8'd0);
    tick();
    // writer to r0 never forwards
    fd(1, 5'd0, 1, 5'd0, 1, 5'd11, 1, ALU); tick();
    settle();
    chk("r0_sel_a", 8'(sela_b), 8'd0);
    chk("r0_sel_b", 8'(selb_b), 8'd0);
    fd_idle(); tick();

    // lw r5 ; add r6,r5,r1
    fd(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, LOAD); tick();
    fd(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, ALU); settle();
    chk("lduse_stall1", 8'(stall_b), 8'd1);
    tick(); settle();
    chk("lduse_stall2", 8'(stall_b), 8'd0);
    tick();
    fd(1, 5'd5, 1, 5'd6, 1, 5'd12, 1, ALU); settle();
    chk("lduse_stall3", 8'(stall_b), 8'd0);
    chk("lduse_sel_a",  8'(sela_b),  8'd2);
    chk("lduse_sel_b",  8'(selb_b),  8'd0);
    tick(); settle();
    chk("mix_sel_a", 8'(sela_b), 8'd0);
    chk("mix_sel_b", 8'(selb_b), 8'd1);

    // mul r7 ; add r8,r7
    fd(1, 5'd1, 1, 5'd2, 1, 5'd7, 1, MD); settle();
    chk("mul7_stall", 8'(stall_b), 8'd0);
    tick();
    fd(1, 5'd7, 1, 5'd0, 0, 5'd8, 1, ALU); settle();
    chk("raw_dx_stall", 8'(stall_b), 8'd1);
    chk("raw_dx_busy",  8'(busy_b),  8'd0);
    tick(); settle();
    chk("raw_b3_stall", 8'(stall_b), 8'd1);
    chk("raw_b3_busy",  8'(busy_b),  8'd1);
    tick(); settle();
    chk("raw_b2_stall", 8'(stall_b), 8'd1);
    tick(); settle();
    chk("raw_b1_stall", 8'(stall_b), 8'd1);
    tick(); settle();
    chk("raw_b0_stall", 8'(stall_b), 8'd1);
    chk("raw_b0_wbv",   8'(wbv_b),   8'd0);
    tick(); settle();
    chk("done_wbv",   8'(wbv_b),   8'd1);
    chk("done_wbd",   8'(wbd_b),   8'd7);
    chk("done_stall", 8'(stall_b), 8'd1);
    chk("done_busy",  8'(busy_b),  8'd1);
    tick(); settle();
    chk("idle_stall", 8'(stall_b), 8'd0);
    chk("idle_wbv",   8'(wbv_b),   8'd0);
    chk("idle_busy",  8'(busy_b),  8'd0);
    tick();

    // mul r14 ; mul r15 (structural) ; store / add r16 at count 2
    fd(1, 5'd1, 1, 5'd2, 1, 5'd14, 1, MD); settle();
    chk("mul14_stall", 8'(stall_b), 8'd0);
    tick();
    fd(1, 5'd1, 1, 5'd2, 1, 5'd15, 1, MD); settle();
    chk("mul15_dx_stall", 8'(stall_b), 8'd1);
    tick(); settle();
    chk("mul15_busy_stall", 8'(stall_b), 8'd1);
    fd(1, 5'd1, 1, 5'd2, 1, 5'd0, 0, NW); settle();
    chk("store_c3_stall", 8'(stall_b), 8'd0);
    tick(); settle();
    chk("store_c2_stall", 8'(stall_b), 8'd0);
    fd(1, 5'd1, 1, 5'd2, 1, 5'd16, 1, ALU); settle();
    chk("wbport_c2_stall", 8'(stall_b), 8'd1);
    tick(); settle();
    chk("wbport_c1_stall", 8'(stall_b), 8'd0);
    tick();
    fd_idle(); tick(); settle();
    chk("mul14_wbv", 8'(wbv_b), 8'd1);
    chk("mul14_wbd", 8'(wbd_b), 8'd14);
    tick();

    // reset while BUSY
    fd(1, 5'd1, 1, 5'd2, 1, 5'd20, 1, MD); tick();
    fd_idle(); tick(); tick();
    fd(1, 5'd1, 1, 5'd2, 1, 5'd17, 1, ALU); settle();
    chk("pre_rst_stall", 8'(stall_b), 8'd1);
    chk("pre_rst_busy",  8'(busy_b),  8'd1);
    reset = 1'b1; settle();
    chk("inrst_stall", 8'(stall_b), 8'd0);
    chk("inrst_busy",  8'(busy_b),  8'd0);
    chk("inrst_wbv",   8'(wbv_b),   8'd0);
    chk("inrst_wbd",   8'(wbd_b),   8'd0);
    chk("inrst_sel_a", 8'(sela_b),  8'd0);
    chk("inrst_sel_b", 8'(selb_b),  8'd0);
    chk("inrst_stall_s", 8'(stall_s), 8'd0);
    chk("inrst_busy_s",  8'(busy_s),  8'd0);
    tick();
    reset = 1'b0;
    fd_idle(); settle();
    chk("postrst_busy", 8'(busy_b), 8'd0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (wbv_b === 1'b1) pulses++;
    end
    chk("postrst_no_wb", 8'(pulses), 8'd0);

    // stall-only instance: add r3 ; add r4,r3
    fd(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, ALU); settle();
    chk("nb_add3_stall", 8'(stall_s), 8'd0);
    tick();
    fd(1, 5'd3, 1, 5'd0, 0, 5'd4, 1, ALU); settle();
    chk("nb_dx_stall",  8'(stall_s), 8'd1);
    chk("byp_dx_stall", 8'(stall_b), 8'd0);
    tick(); settle();
    chk("nb_xm_stall", 8'(stall_s), 8'd1);
    chk("nb_xm_sel_a", 8'(sela_s),  8'd0);
    chk("byp_xm_sel_a", 8'(sela_b), 8'd1);
    tick(); settle();
    chk("nb_mw_stall", 8'(stall_s), 8'd1);
    flush = 1'b1; settle();
    chk("nb_flush_stall", 8'(stall_s), 8'd0);
    tick();
    flush = 1'b0;
    // flush of an otherwise-issuing writer must leave a bubble in DX
    fd(1, 5'd1, 1, 5'd2, 1, 5'd4, 1, ALU);
    flush = 1'b1; settle();
    chk("nb_flush2_stall", 8'(stall_s), 8'd0);
    tick();
    flush = 1'b0;
    fd(1, 5'd4, 1, 5'd0, 0, 5'd5, 1, ALU); settle();
    chk("nb_flushed_dx", 8'(stall_s), 8'd0);
    tick();
    fd_idle(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
